// File: rtl/addsub_acc_seq.sv
// rtl/addsub_acc_seq.sv - command sequencer and register stage around an external add/sub stage
// Optional build macro: ADDACC_SATURATE_EN (clamps ADD/SUB results and adds AddAcc_o_sat)
module addsub_acc_seq #(
  parameter int WIDTH = 4
) (
  input  logic             AddAcc_i_clk,
  input  logic             AddAcc_i_rst,
  input  logic             AddAcc_i_valid,
  output logic             AddAcc_o_ready,
  input  logic [1:0]       AddAcc_i_op,
  input  logic [WIDTH-1:0] AddAcc_i_data,
  output logic [WIDTH-1:0] AddAcc_o_A,
  output logic [WIDTH-1:0] AddAcc_o_B,
  output logic             AddAcc_o_fSub,
  input  logic [WIDTH-1:0] AddAcc_i_S,
  input  logic             AddAcc_i_C,
  output logic             AddAcc_o_valid,
  input  logic             AddAcc_i_ready,
  output logic [WIDTH-1:0] AddAcc_o_acc,
  output logic [2:0]       AddAcc_o_flags
`ifdef ADDACC_SATURATE_EN
  ,
  output logic             AddAcc_o_sat
`endif
);

  localparam int MSB = WIDTH - 1;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_ADD   = 2'b01;
  localparam logic [1:0] OP_SUB   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t           r_state;
  state_t           w_next_state;

  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_operand;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_acc;
  logic             r_c;
  logic             r_z;
  logic             r_v;
  logic             r_sat;

  logic             w_ready;
  logic             w_valid;
  logic             w_fsub;
  logic             w_accept;

  logic [WIDTH-1:0] w_bx;
  logic             w_v_raw;
  logic [WIDTH-1:0] w_new_acc;
  logic             w_new_c;
  logic             w_new_v;
  logic             w_new_sat;

  // State register: the only place the transaction phase advances or is discarded by reset.
  always_ff @(posedge AddAcc_i_clk or posedge AddAcc_i_rst) begin
    if (AddAcc_i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and handshake/adder-control decode from the current phase.
  always_comb begin
    w_next_state = r_state;
    w_ready      = 1'b0;
    w_valid      = 1'b0;
    w_fsub       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ready = 1'b1;
        if (AddAcc_i_valid) begin
          w_next_state = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_fsub       = (r_op == OP_SUB);
        w_next_state = ST_DONE;
      end
      ST_DONE: begin
        w_valid = 1'b1;
        if (AddAcc_i_ready) begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  assign w_accept = (r_state == ST_IDLE) && AddAcc_i_valid;

  // Result selection: signed overflow uses the effective B the adder actually saw.
  always_comb begin
    w_bx      = (r_op == OP_SUB) ? ~r_operand : r_operand;
    w_v_raw   = (r_a[MSB] == w_bx[MSB]) && (AddAcc_i_S[MSB] != r_a[MSB]);
    w_new_acc = '0;
    w_new_c   = 1'b0;
    w_new_v   = 1'b0;
    w_new_sat = 1'b0;
    case (r_op)
      OP_LOAD: begin
        w_new_acc = r_operand;
      end
      OP_ADD: begin
        w_new_acc = AddAcc_i_S;
        w_new_c   = AddAcc_i_C;
        w_new_v   = w_v_raw;
`ifdef ADDACC_SATURATE_EN
        if (AddAcc_i_C) begin
          w_new_acc = '1;
          w_new_sat = 1'b1;
        end
`endif
      end
      OP_SUB: begin
        w_new_acc = AddAcc_i_S;
        w_new_c   = AddAcc_i_C;
        w_new_v   = w_v_raw;
`ifdef ADDACC_SATURATE_EN
        if (!AddAcc_i_C) begin
          w_new_acc = '0;
          w_new_sat = 1'b1;
        end
`endif
      end
      OP_CLEAR: begin
        w_new_acc = '0;
      end
      default: begin
        w_new_acc = r_acc;
      end
    endcase
  end

  // Command latch on accept, and accumulator/flag update at the end of the execute cycle.
  always_ff @(posedge AddAcc_i_clk or posedge AddAcc_i_rst) begin
    if (AddAcc_i_rst) begin
      r_op      <= OP_LOAD;
      r_operand <= '0;
      r_a       <= '0;
      r_acc     <= '0;
      r_c       <= 1'b0;
      r_z       <= 1'b0;
      r_v       <= 1'b0;
      r_sat     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op      <= AddAcc_i_op;
        r_operand <= AddAcc_i_data;
        r_a       <= r_acc;
      end
      if (r_state == ST_EXEC) begin
        r_acc <= w_new_acc;
        r_c   <= w_new_c;
        r_v   <= w_new_v;
        r_z   <= (w_new_acc == '0);
        r_sat <= w_new_sat;
      end
    end
  end

  // o_A/o_B are the latched copies, so they hold their last values outside execute.
  assign AddAcc_o_ready = w_ready & ~AddAcc_i_rst;
  assign AddAcc_o_valid = w_valid;
  assign AddAcc_o_fSub  = w_fsub;
  assign AddAcc_o_A     = r_a;
  assign AddAcc_o_B     = r_operand;
  assign AddAcc_o_acc   = r_acc;
  assign AddAcc_o_flags = {r_c, r_z, r_v};
`ifdef ADDACC_SATURATE_EN
  assign AddAcc_o_sat   = r_sat & (r_state == ST_DONE);
`endif

endmodule

// File: tb/tb_addsub_acc_seq.sv
// tb/tb_addsub_acc_seq.sv - self-checking bench for addsub_acc_seq with a behavioural adder attached
module tb_addsub_acc_seq;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_valid;
  logic         o_ready;
  logic [1:0]   i_op;
  logic [W-1:0] i_data;
  logic [W-1:0] o_A;
  logic [W-1:0] o_B;
  logic         o_fSub;
  logic [W-1:0] w_S;
  logic         w_C;
  logic         o_valid;
  logic         i_ready;
  logic [W-1:0] o_acc;
  logic [2:0]   o_flags;
`ifdef ADDACC_SATURATE_EN
  logic         o_sat;
`endif

  int total = 0;
  int bad   = 0;

  int m_acc;
  bit m_c;
  bit m_z;
  bit m_v;
  bit m_sat;

  always #5 clk = ~clk;

  // External combinational add/sub stage: S = A + B, or A - B as A + ~B + 1.
  logic [W:0] w_sum;
  assign w_sum = {1'b0, o_A} + {1'b0, (o_fSub ? ~o_B : o_B)} + {{W{1'b0}}, o_fSub};
  assign w_S   = w_sum[W-1:0];
  assign w_C   = w_sum[W];

  addsub_acc_seq #(.WIDTH(W)) dut (
    .AddAcc_i_clk   (clk),
    .AddAcc_i_rst   (rst),
    .AddAcc_i_valid (i_valid),
    .AddAcc_o_ready (o_ready),
    .AddAcc_i_op    (i_op),
    .AddAcc_i_data  (i_data),
    .AddAcc_o_A     (o_A),
    .AddAcc_o_B     (o_B),
    .AddAcc_o_fSub  (o_fSub),
    .AddAcc_i_S     (w_S),
    .AddAcc_i_C     (w_C),
    .AddAcc_o_valid (o_valid),
    .AddAcc_i_ready (i_ready),
    .AddAcc_o_acc   (o_acc),
    .AddAcc_o_flags (o_flags)
`ifdef ADDACC_SATURATE_EN
    ,
    .AddAcc_o_sat   (o_sat)
`endif
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: unsigned and two's-complement integer arithmetic on the 4-bit values.
  task automatic model(input int op, input int d);
    int sa;
    int sd;
    int r;
    sa    = (m_acc > 7) ? m_acc - 16 : m_acc;
    sd    = (d > 7) ? d - 16 : d;
    m_sat = 0;
    case (op)
      0: begin m_acc = d; m_c = 0; m_v = 0; end
      1: begin
        r     = m_acc + d;
        m_c   = (r > 15);
        m_v   = ((sa + sd) > 7) || ((sa + sd) < -8);
        m_acc = r % 16;
`ifdef ADDACC_SATURATE_EN
        if (r > 15) begin m_acc = 15; m_sat = 1; end
`endif
      end
      2: begin
        m_c   = (m_acc >= d);
        m_v   = ((sa - sd) > 7) || ((sa - sd) < -8);
        r     = m_acc - d;
        m_acc = (r + 16) % 16;
`ifdef ADDACC_SATURATE_EN
        if (r < 0) begin m_acc = 0; m_sat = 1; end
`endif
      end
      default: begin m_acc = 0; m_c = 0; m_v = 0; end
    endcase
    m_z = (m_acc == 0);
  endtask

  task automatic chk_result(input string tag);
    chk({tag, "_acc"}, 8'(o_acc), 8'(m_acc));
    chk({tag, "_flags"}, 8'(o_flags), 8'({m_c, m_z, m_v}));
`ifdef ADDACC_SATURATE_EN
    chk({tag, "_sat"}, 8'(o_sat), 8'(m_sat));
`endif
  endtask

  // One full transaction; called at a negedge, returns at a negedge back in the idle phase.
  task automatic send(input logic [1:0] op, input logic [W-1:0] d, input int hold);
    int n;
    int a_before;
    a_before = m_acc;
    n = 0;
    while (!o_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_cmd", 8'(o_ready), 8'd1);
    i_valid = 1'b1;
    i_op    = op;
    i_data  = d;
    @(negedge clk);
    i_valid = 1'b0;
    i_data  = W'($urandom);
    chk("exec_valid", 8'(o_valid), 8'd0);
    chk("exec_ready", 8'(o_ready), 8'd0);
    chk("exec_fsub", 8'(o_fSub), 8'(op == 2'b10));
    chk("exec_A", 8'(o_A), 8'(a_before));
    chk("exec_B", 8'(o_B), 8'(d));
    @(negedge clk);
    chk("done_latency_valid", 8'(o_valid), 8'd1);
    chk("done_fsub", 8'(o_fSub), 8'd0);
    model(int'(op), int'(d));
    chk_result("done");
    for (int k = 0; k < hold; k++) begin
      i_ready = 1'b0;
      i_valid = 1'($urandom);
      i_op    = 2'($urandom);
      i_data  = W'($urandom);
      @(negedge clk);
      chk("hold_valid", 8'(o_valid), 8'd1);
      chk("hold_ready", 8'(o_ready), 8'd0);
      chk_result("hold");
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(negedge clk);
    chk("consumed_valid", 8'(o_valid), 8'd0);
    chk("consumed_ready", 8'(o_ready), 8'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    i_valid = 1'b0;
    i_op    = 2'b00;
    i_data  = '0;
    i_ready = 1'b1;
    m_acc = 0; m_c = 0; m_z = 0; m_v = 0; m_sat = 0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 8'(o_ready), 8'd0);
    chk("rst_valid", 8'(o_valid), 8'd0);
    chk("rst_acc", 8'(o_acc), 8'd0);
    chk("rst_flags", 8'(o_flags), 8'd0);
    chk("rst_fsub", 8'(o_fSub), 8'd0);
`ifdef ADDACC_SATURATE_EN
    chk("rst_sat", 8'(o_sat), 8'd0);
`endif
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 8'(o_ready), 8'd1);

    // Borrowing subtraction, signed overflow on ADD, non-overflowing SUB, wrap to zero.
    send(2'b00, 4'd10, 0);
    send(2'b10, 4'd12, 0);
    send(2'b00, 4'd5, 0);
    send(2'b01, 4'd7, 0);
    send(2'b00, 4'd9, 0);
    send(2'b10, 4'd8, 0);
    send(2'b01, 4'd15, 0);

    // Result held while the consumer stalls; inputs toggle but nothing is accepted.
    send(2'b00, 4'd6, 0);
    send(2'b01, 4'd2, 5);
    send(2'b10, 4'd1, 0);

    // Reset while executing: transaction is dropped, accumulator clears.
    send(2'b00, 4'd4, 0);
    i_valid = 1'b1;
    i_op    = 2'b01;
    i_data  = 4'd3;
    @(negedge clk);
    i_valid = 1'b0;
    rst     = 1'b1;
    #1;
    chk("midrst_ready", 8'(o_ready), 8'd0);
    chk("midrst_valid", 8'(o_valid), 8'd0);
    chk("midrst_acc", 8'(o_acc), 8'd0);
    chk("midrst_fsub", 8'(o_fSub), 8'd0);
    @(negedge clk);
    rst = 1'b0;
    m_acc = 0; m_c = 0; m_z = 0; m_v = 0; m_sat = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("after_midrst_valid", 8'(o_valid), 8'd0);
      chk("after_midrst_ready", 8'(o_ready), 8'd1);
    end

    // Back-to-back commands with the consumer always ready.
    send(2'b00, 4'd3, 0);
    send(2'b11, 4'd9, 0);
    send(2'b01, 4'd1, 0);

    // Randomized command stream against the reference model.
    for (int k = 0; k < 40; k++) begin
      send(2'($urandom_range(0, 3)), W'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
